seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the generalised successor of the fixed 4-bit Mealy detectors in the FSM guide series. It detects any N-bit pattern on a 1-bit serial input, with selectable overlapping or non-overlapping matching. It provides both a Mealy (combinational) and a registered match output, plus a saturating match counter. It sits after a serial bit source and feeds status or counter logic.

Parameters:
N, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1101, N-bit target; PATTERN[N-1] is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = search restarts from empty after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low; forces all state to reset values.
en  input  1  bit-valid; x is sampled only when en=1.
clr  input  1  synchronous clear of state and counter.
x  input  1  serial data bit.
y  output  1  Mealy match: combinational, same cycle as the final pattern bit.
y_q  output  1  y registered; high exactly one cycle after y.
count  output  CNT_W  number of matches, saturating.
state  output  $clog2(N)  current matched-prefix length, 0..N-1 (debug).

Behaviour:
- State semantics: state = length of the longest suffix of accepted bits that equals a proper prefix of the pattern (KMP automaton). Transitions are computed from PATTERN at elaboration (or from the loaded pattern; see Optional Feature). Hand-coded tables are not allowed.
- Reset (reset=0, async): state=0, y_q=0, count=0. y=0 while in reset.
- y = en & (state==N-1) & (x==pattern[0]) & ~clr. Purely combinational, with no registered delay.
- On each rising clk edge:
  - If clr=1: state<=0, count<=0, y_q<=0. clr overrides en.
  - Else if en=0: state, count and y_q hold. y is 0.
  - Else (en=1):
    - On a match with OVERLAP=1: state <= the length of the longest proper border of the full pattern.
    - On a match with OVERLAP=0: state <= 0.
    - On a non-match: state <= the KMP next state.
    - y_q <= y.
    - count <= count+1 on a match, held at 2^CNT_W-1 (no wrap).
- Latency: y is 0 cycles after the last pattern bit; y_q and count update at the edge that consumes that bit.
- Periods with en=0 are transparent: the pattern may be split across them.
- Async reset asserted mid-pattern discards the partial match. Bits after reset release are matched from empty.
- state never reaches N.

Optional Feature:
Macro SEQDET_PAT_LOAD_EN.
- Defined: adds ports load (input, 1) and pat_in (input, N).
  - Pattern register resets to PATTERN.
  - On an edge with load=1: pattern <= pat_in, state <= 0, y_q <= 0; count holds.
  - load has priority over en and lower priority than clr (clr clears state and count; the pattern is still loaded if both are asserted).
  - y is 0 while load=1.
  - Transitions are computed combinationally from the pattern register.
- Undefined: the ports are absent and the pattern is the constant PATTERN.

Test Plan:
1. Defaults, en=1, x stream 1,1,0,1,1,0,1 → y high on bits 4 and 7; y_q high the cycle after each; count=2.
2. OVERLAP=0, same stream 1,1,0,1,1,0,1 → y only on bit 4; count=1. Stream 1,1,0,1,1,1,0,1 → y on bits 4 and 8; count=2.
3. Stream 1,1,0; async reset pulse; then 1 → no y; state=1 after the final bit; count=0.
4. Stream 1,1 then en=0 for 3 cycles with x=0, then en=1 with 0,1 → y on the final bit; count=1. No y and no state change while en=0.
5. CNT_W=2, stream 1101 repeated 5 times → count 1,2,3,3,3; y pulses all 5 times. Assert clr → count=0 and state=0 next edge.
6. With SEQDET_PAT_LOAD_EN: load pat_in=4'b0110, then stream 0,1,1,0,1,1,0 → y on bits 4 and 7; count=2. The old pattern 1101 no longer matches.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Serial pattern detector bus: bit stream in, match status out.
// SEQDET_PAT_LOAD_EN adds the runtime pattern load signals.
interface seq_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic                 en;
  logic                 clr;
  logic                 x;
  logic                 y;
  logic                 y_q;
  logic [CNT_W-1:0]     count;
  logic [$clog2(N)-1:0] state;
`ifdef SEQDET_PAT_LOAD_EN
  logic                 load;
  logic [N-1:0]         pat_in;

  modport master (
    output en, clr, x, load, pat_in,
    input  y, y_q, count, state
  );
  modport slave (
    input  en, clr, x, load, pat_in,
    output y, y_q, count, state
  );
`else
  modport master (
    output en, clr, x,
    input  y, y_q, count, state
  );
  modport slave (
    input  en, clr, x,
    output y, y_q, count, state
  );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// KMP-style serial pattern detector, Mealy + registered match, sat counter.
// SEQDET_PAT_LOAD_EN: pattern becomes a register loadable via load/pat_in.
module seq_detector_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter int           OVERLAP = 1,
  parameter int           CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  seq_detector_param_if.slave bus
);
  localparam int SW = $clog2(N);

  // Longest suffix of (prefix[s] . b) that is a proper prefix of pat.
  function automatic logic [SW-1:0] kmp_next(
    input logic [N-1:0]  pat,
    input logic [SW-1:0] s,
    input logic          b
  );
    logic [SW-1:0] res;
    logic          ok;
    logic          c;
    int            idx;
    res = '0;
    for (int k = 1; k < N; k++) begin
      if (k <= int'(s) + 1) begin
        ok = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (j < k) begin
            idx = int'(s) + 1 - k + j;
            c   = (idx == int'(s)) ? b : pat[N-1-idx];
            if (c != pat[N-1-j]) ok = 1'b0;
          end
        end
        if (ok) res = SW'(k);
      end
    end
    return res;
  endfunction

  logic [N-1:0]     pat;
  logic             ld;
  logic [SW-1:0]    state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit;
  logic [SW-1:0]    nxt;

`ifdef SEQDET_PAT_LOAD_EN
  logic [N-1:0] pat_q, pat_d;

  // Pattern register takes pat_in whenever load is asserted.
  always_comb begin
    pat_d = pat_q;
    if (bus.load) pat_d = bus.pat_in;
  end

  // Pattern register; resets to the elaborated pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pat_q <= PATTERN;
    else        pat_q <= pat_d;
  end

  assign pat = pat_q;
  assign ld  = bus.load;
`else
  assign pat = PATTERN;
  assign ld  = 1'b0;
`endif

  assign hit = bus.en & ~bus.clr & ~ld
             & (state_q == SW'(N - 1))
             & (bus.x == pat[0]);
  assign nxt = kmp_next(pat, state_q, bus.x);

  // Next-state: clr beats load beats en; match may restart or follow border.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    count_d = count_q;
    if (bus.clr) begin
      state_d = '0;
      match_d = 1'b0;
      count_d = '0;
    end else if (ld) begin
      state_d = '0;
      match_d = 1'b0;
    end else if (bus.en) begin
      state_d = (hit && OVERLAP == 0) ? '0 : nxt;
      match_d = hit;
      if (hit && count_q != '1) count_d = count_q + CNT_W'(1);
    end
  end

  // Detector state, registered match and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign bus.y     = hit;
  assign bus.y_q   = match_q;
  assign bus.count = count_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: default, non-overlap and 2-bit-counter detectors.
// Load checks only when SEQDET_PAT_LOAD_EN is defined.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic x = 1'b0;
`ifdef SEQDET_PAT_LOAD_EN
  logic       load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.N(4), .CNT_W(8)) ia ();
  seq_detector_param_if #(.N(4), .CNT_W(8)) ib ();
  seq_detector_param_if #(.N(4), .CNT_W(2)) ic ();

  assign ia.en = en;
  assign ia.clr = clr;
  assign ia.x = x;
  assign ib.en = en;
  assign ib.clr = clr;
  assign ib.x = x;
  assign ic.en = en;
  assign ic.clr = clr;
  assign ic.x = x;
`ifdef SEQDET_PAT_LOAD_EN
  assign ia.load = load;
  assign ia.pat_in = pat_in;
  assign ib.load = load;
  assign ib.pat_in = pat_in;
  assign ic.load = load;
  assign ic.pat_in = pat_in;
`endif

  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(ib));
  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic b);
    @(negedge clk);
    en = e;
    x = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    en = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  logic s1[7] = '{1, 1, 0, 1, 1, 0, 1};
  logic e1a[7] = '{0, 0, 0, 1, 0, 0, 1};
  logic e1b[7] = '{0, 0, 0, 1, 0, 0, 0};
  logic s2[8] = '{1, 1, 0, 1, 1, 1, 0, 1};
  logic e2[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic p4[4] = '{1, 1, 0, 1};
  int   c2[5] = '{1, 2, 3, 3, 3};
`ifdef SEQDET_PAT_LOAD_EN
  logic s6[7] = '{0, 1, 1, 0, 1, 1, 0};
`endif

  initial begin
    #12;
    chk("rst_state", 32'(ia.state), 0);
    chk("rst_yq", 32'(ia.y_q), 0);
    chk("rst_count", 32'(ia.count), 0);
    chk("rst_y", 32'(ia.y), 0);
    @(negedge clk);
    reset = 1'b1;

    // overlap vs non-overlap on 1101101
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s1[i]);
      chk("t1_y", 32'(ia.y), 32'(e1a[i]));
      chk("t1_yno", 32'(ib.y), 32'(e1b[i]));
      tick();
      chk("t1_yq", 32'(ia.y_q), 32'(e1a[i]));
      chk("t1_yqno", 32'(ib.y_q), 32'(e1b[i]));
    end
    chk("t1_cnt", 32'(ia.count), 2);
    chk("t1_cntno", 32'(ib.count), 1);

    // 11011101: both variants match twice
    do_clr();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s2[i]);
      chk("t2_y", 32'(ia.y), 32'(e2[i]));
      chk("t2_yno", 32'(ib.y), 32'(e2[i]));
      tick();
    end
    chk("t2_cnt", 32'(ia.count), 2);
    chk("t2_cntno", 32'(ib.count), 2);

    // 110 then async reset mid-pattern, then 1
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0);
    tick();
    chk("t3_pre_state", 32'(ia.state), 3);
    @(negedge clk);
    en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t3_rst_state", 32'(ia.state), 0);
    chk("t3_rst_count", 32'(ia.count), 0);
    chk("t3_rst_y", 32'(ia.y), 0);
    #1 reset = 1'b1;
    drive(1'b1, 1'b1);
    chk("t3_y", 32'(ia.y), 0);
    tick();
    chk("t3_state", 32'(ia.state), 1);
    chk("t3_cnt", 32'(ia.count), 0);

    // pattern split across en=0 gap
    do_clr();
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      chk("t4_gap_y", 32'(ia.y), 0);
      tick();
      chk("t4_gap_state", 32'(ia.state), 2);
    end
    drive(1'b1, 1'b0);
    chk("t4_y0", 32'(ia.y), 0);
    tick();
    drive(1'b1, 1'b1);
    chk("t4_y1", 32'(ia.y), 1);
    tick();
    chk("t4_cnt", 32'(ia.count), 1);

    // 1101 x5: 2-bit counter saturates
    do_clr();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, p4[i]);
        chk("t5_y", 32'(ic.y), (i == 3) ? 1 : 0);
        tick();
      end
      chk("t5_cnt2", 32'(ic.count), 32'(c2[r]));
    end
    chk("t5_cnt", 32'(ia.count), 5);
    chk("t5_cntno", 32'(ib.count), 5);

    // clr overrides en on what would be a matching bit
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0);
    tick();
    @(negedge clk);
    clr = 1'b1;
    en = 1'b1;
    x = 1'b1;
    #1;
    chk("t5_clr_y", 32'(ia.y), 0);
    tick();
    clr = 1'b0;
    chk("t5_clr_state", 32'(ia.state), 0);
    chk("t5_clr_cnt", 32'(ia.count), 0);
    chk("t5_clr_cnt2", 32'(ic.count), 0);

`ifdef SEQDET_PAT_LOAD_EN
    // one match so count is nonzero, then reach state 3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, p4[i]);
      tick();
    end
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0);
    tick();
    @(negedge clk);
    load = 1'b1;
    pat_in = 4'b0110;
    en = 1'b1;
    x = 1'b1;
    #1;
    chk("t6_load_y", 32'(ia.y), 0);
    tick();
    load = 1'b0;
    chk("t6_load_state", 32'(ia.state), 0);
    chk("t6_load_cnt", 32'(ia.count), 1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s6[i]);
      chk("t6_y", 32'(ia.y), (i == 3 || i == 6) ? 1 : 0);
      tick();
    end
    chk("t6_cnt", 32'(ia.count), 3);
    do_clr();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, p4[i]);
      chk("t6_old_y", 32'(ia.y), 0);
      tick();
    end
    chk("t6_old_cnt", 32'(ia.count), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
